// File: rtl/roe_pkg.sv
// Shared types and constants for the run controller and the decoder that feeds it.
package roe_pkg;

    localparam int PC_W = 10;

    // Opcode the decoder recognises as halt; it raises run_ctrl's halt input.
    localparam logic [5:0] HALT_OPCODE = 6'h3f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

endpackage

// File: rtl/run_watchdog.sv
// Clearable, enabled cycle counter; tc flags the last allowed RUN cycle.
module run_watchdog #(
    parameter int WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WDOG_CYC);
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/run_ctrl.sv
// Host req/ack run controller: loads the resume PC, enables execution until halt
// or watchdog expiry, then acknowledges. state is exported for debug visibility.
module run_ctrl
    import roe_pkg::*;
#(
    parameter int PC_W     = roe_pkg::PC_W,
    parameter int START_PC = 0,
    parameter int WDOG_CYC = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            halt,
    input  logic [PC_W-1:0] pc,
    output logic            pc_init,
    output logic [PC_W-1:0] pc_start,
    output logic            run_en,
    output logic            ack,
    output logic            timeout,
    output run_state_t      state
);

    run_state_t      state_next;
    logic            req_q;
    logic            start;
    logic [PC_W-1:0] resume_pc;
    logic            wd_tc;

    assign start = req & ~req_q;

    run_watchdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .en    (state == RUN),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            resume_pc <= PC_W'(START_PC);
            timeout   <= 1'b0;
        end else begin
            state <= state_next;
            req_q <= req;
            if (state == LOAD) begin
                timeout <= 1'b0;
            end
            // Halt has priority over the watchdog: a halting run is never a timeout.
            if (state == RUN) begin
                if (halt) begin
                    resume_pc <= pc + 1'b1;
                end else if (wd_tc) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_init    = 1'b0;
        run_en     = 1'b0;
        ack        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                pc_init    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                run_en = ~halt;
                if (halt || wd_tc) state_next = DONE;
            end
            DONE: begin
                ack = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc_start = resume_pc;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed, table-driven bench for run_ctrl with a short watchdog (WDOG_CYC=8).
module tb_run_ctrl;
    import roe_pkg::*;

    localparam int PCW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            req;
    logic            halt;
    logic [PCW-1:0]  pc;
    logic            pc_init;
    logic [PCW-1:0]  pc_start;
    logic            run_en;
    logic            ack;
    logic            timeout;
    run_state_t      state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .PC_W     (PCW),
        .START_PC (0),
        .WDOG_CYC (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .halt     (halt),
        .pc       (pc),
        .pc_init  (pc_init),
        .pc_start (pc_start),
        .run_en   (run_en),
        .ack      (ack),
        .timeout  (timeout),
        .state    (state)
    );

    typedef struct {
        logic           rst;
        logic           rq;
        logic           hl;
        logic [PCW-1:0] p;
        logic           e_init;
        logic [PCW-1:0] e_start;
        logic           e_run;
        logic           e_ack;
        logic           e_tmo;
        run_state_t     e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic q, input logic h, input int p,
                                input logic ei, input int es, input logic ee,
                                input logic ea, input logic et, input run_state_t st);
        vec_t v;
        v.rst = r; v.rq = q; v.hl = h; v.p = PCW'(p);
        v.e_init = ei; v.e_start = PCW'(es); v.e_run = ee;
        v.e_ack = ea; v.e_tmo = et; v.e_state = st;
        return v;
    endfunction

    task automatic add(input logic r, input logic q, input logic h, input int p,
                       input logic ei, input int es, input logic ee,
                       input logic ea, input logic et, input run_state_t st);
        vecs.push_back(mk(r, q, h, p, ei, es, ee, ea, et, st));
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check outputs before the next rise.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; req = v.rq; halt = v.hl; pc = v.p;
        #1;
        chk("pc_init",  idx, 32'(pc_init),  32'(v.e_init));
        chk("pc_start", idx, 32'(pc_start), 32'(v.e_start));
        chk("run_en",   idx, 32'(run_en),   32'(v.e_run));
        chk("ack",      idx, 32'(ack),      32'(v.e_ack));
        chk("timeout",  idx, 32'(timeout),  32'(v.e_tmo));
        chk("state",    idx, 32'(state),    32'(v.e_state));
    endtask

    initial begin
        // Reset with req held high: req_q clears, so the first free edge sees a rise.
        reset = 1'b1; req = 1'b1; halt = 1'b0; pc = '0;
        repeat (2) @(posedge clk);

        add(0,1,0,0,    0,0,0,0,0,IDLE);
        add(0,0,0,0,    1,0,0,0,0,LOAD);
        add(0,0,1,3,    0,0,0,0,0,RUN);
        add(0,0,0,0,    0,4,0,1,0,DONE);
        // Second request: ack falls on the start edge, 5 commits then halt at 9.
        add(0,1,0,0,    0,4,0,1,0,DONE);
        add(0,0,0,0,    1,4,0,0,0,LOAD);
        for (int i = 0; i < 5; i++) add(0,0,0,4+i, 0,4,1,0,0,RUN);
        add(0,0,1,9,    0,4,0,0,0,RUN);
        add(0,0,0,0,    0,10,0,1,0,DONE);
        // Watchdog run: 8 enabled cycles, timeout, resume_pc untouched.
        add(0,1,0,0,    0,10,0,1,0,DONE);
        add(0,0,0,0,    1,10,0,0,0,LOAD);
        for (int i = 0; i < 8; i++) add(0,0,0,10+i, 0,10,1,0,0,RUN);
        add(0,0,0,0,    0,10,0,1,1,DONE);
        add(0,1,0,0,    0,10,0,1,1,DONE);
        add(0,0,0,0,    1,10,0,0,1,LOAD);
        // Timeout cleared by LOAD; halt at the top address wraps resume_pc to 0.
        add(0,0,1,1023, 0,10,0,0,0,RUN);
        add(0,0,0,0,    0,0,0,1,0,DONE);
        // Extra req: held through LOAD, fresh rise during RUN; neither is queued.
        add(0,1,0,0,    0,0,0,1,0,DONE);
        add(0,1,0,0,    1,0,0,0,0,LOAD);
        add(0,0,0,0,    0,0,1,0,0,RUN);
        add(0,1,0,1,    0,0,1,0,0,RUN);
        add(0,0,1,2,    0,0,0,0,0,RUN);
        add(0,0,0,0,    0,3,0,1,0,DONE);
        add(0,0,0,0,    0,3,0,1,0,DONE);
        // Reset mid-RUN: back to IDLE with resume_pc at START_PC and no ack.
        add(0,1,0,0,    0,3,0,1,0,DONE);
        add(0,0,0,0,    1,3,0,0,0,LOAD);
        add(1,0,0,3,    0,3,1,0,0,RUN);
        add(0,0,0,0,    0,0,0,0,0,IDLE);
        add(0,0,0,0,    0,0,0,0,0,IDLE);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Halt coinciding with the watchdog terminal count: halt wins.
        step(mk(0,1,0,0,   0,0,0,0,0,IDLE), 100);
        step(mk(0,0,0,0,   1,0,0,0,0,LOAD), 101);
        for (int i = 0; i < 7; i++) step(mk(0,0,0,i, 0,0,1,0,0,RUN), 102 + i);
        step(mk(0,0,1,500, 0,0,0,0,0,RUN), 109);
        step(mk(0,0,0,0,   0,501,0,1,0,DONE), 110);
        step(mk(0,0,0,0,   0,501,0,1,0,DONE), 111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
